// File: rtl/fsk_pkg.sv
// -----------------------------------------------------------------------------
// fsk_pkg
// Shared types and default constants for the FSK frame transmitter.
//   fsk_tx_state_t : framer state encoding (IDLE, START, DATA, PARITY, STOP)
//   DEF_*          : default timing parameters (clk cycles)
//   cnt_width()    : counter width helper, never narrower than one bit
// -----------------------------------------------------------------------------
package fsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } fsk_tx_state_t;

    localparam int unsigned DEF_BIT_CYCLES = 16;
    localparam int unsigned DEF_HALF0      = 4;
    localparam int unsigned DEF_HALF1      = 2;

    // Width needed to count 0..n-1; a single-value counter still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : fsk_pkg

// File: rtl/fsk_carrier_gen.sv
// -----------------------------------------------------------------------------
// fsk_carrier_gen
// Continuous-phase two-tone square-wave generator. The half-period counter is
// never reset at bit boundaries, so the carrier phase is continuous across
// tone changes.
// Ports:
//   clk      in  system clock, posedge
//   rst      in  synchronous active-low reset
//   tone_sel in  1 = mark tone (HALF1), 0 = space tone (HALF0)
//   fsk_out  out carrier square wave
// -----------------------------------------------------------------------------
module fsk_carrier_gen
    import fsk_pkg::*;
#(
    parameter int unsigned HALF0 = DEF_HALF0,
    parameter int unsigned HALF1 = DEF_HALF1
) (
    input  logic clk,
    input  logic rst,
    input  logic tone_sel,
    output logic fsk_out
);

    localparam int unsigned CW = cnt_width((HALF0 > HALF1) ? HALF0 : HALF1);
    localparam logic [CW-1:0] LIM0 = CW'(HALF0 - 1);
    localparam logic [CW-1:0] LIM1 = CW'(HALF1 - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          fsk_q, fsk_d;
    logic [CW-1:0] lim;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        lim   = tone_sel ? LIM1 : LIM0;
        cnt_d = cnt_q + CW'(1);
        fsk_d = fsk_q;
        // >= rather than ==: after a switch to the shorter tone the counter
        // may already be past the new limit and must toggle immediately.
        if (cnt_q >= lim) begin
            cnt_d = '0;
            fsk_d = ~fsk_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            fsk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            fsk_q <= fsk_d;
        end
    end

    assign fsk_out = fsk_q;

endmodule : fsk_carrier_gen

// File: rtl/fsk_frame_tx.sv
// -----------------------------------------------------------------------------
// fsk_frame_tx
// UART-style framer plus FSK modulator. Each accepted 8-bit word is sent as
// start(0), 8 data bits LSB first, optional even parity, stop(1); each bit is
// held BIT_CYCLES clocks. The carrier tone follows the current line bit.
// Ports:
//   clk        in  system clock, posedge
//   rst        in  synchronous active-low reset
//   word       in  data word, sampled on acceptance
//   word_valid in  word available (level)
//   ready      out word can be accepted this cycle
//   line_bit   out current serialized bit (idle = 1)
//   busy       out frame in progress
//   frame_done out one-cycle pulse in the last STOP cycle
//   fsk_out    out FSK carrier
// -----------------------------------------------------------------------------
module fsk_frame_tx
    import fsk_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int unsigned HALF0      = DEF_HALF0,
    parameter int unsigned HALF1      = DEF_HALF1,
    parameter bit          PARITY_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] word,
    input  logic       word_valid,
    output logic       ready,
    output logic       line_bit,
    output logic       busy,
    output logic       frame_done,
    output logic       fsk_out
);

    localparam int unsigned   BW       = cnt_width(BIT_CYCLES);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYCLES - 1);

    fsk_tx_state_t state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;

    logic bit_last;
    logic stop_last;
    logic accept;

    assign bit_last  = (bit_cnt_q == BIT_LAST);
    assign stop_last = (state_q == ST_STOP) && bit_last;
    // Ready in the last stop cycle lets a waiting word start with zero gap.
    assign ready     = (state_q == ST_IDLE) || stop_last;
    assign accept    = word_valid && ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_last ? '0 : bit_cnt_q + BW'(1);
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (accept) begin
                    state_d = ST_START;
                    shreg_d = word;
                    par_d   = ^word;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    if (accept) begin
                        state_d = ST_START;
                        shreg_d = word;
                        par_d   = ^word;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= 3'd0;
            shreg_q   <= 8'h00;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shreg_q[0];
            ST_PARITY: line_bit = par_q;
            default:   line_bit = 1'b1;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = stop_last;

    fsk_carrier_gen #(
        .HALF0 (HALF0),
        .HALF1 (HALF1)
    ) u_carrier (
        .clk      (clk),
        .rst      (rst),
        .tone_sel (line_bit),
        .fsk_out  (fsk_out)
    );

endmodule : fsk_frame_tx

// File: doc/fsk_frame_tx.md
# fsk_frame_tx

Transmit framer and FSK modulator directly downstream of the word generator. Accepts 8-bit words over a valid/ready handshake and serializes each one as a UART-style frame: start bit, 8 data bits LSB first, optional even parity, stop bit. Drives a continuous-phase two-tone square-wave carrier whose tone follows the current line bit. Its output feeds the channel/DAC stage.

## Interface
Parameters:
- BIT_CYCLES, 16 — clk cycles per transmitted bit; ≥2.
- HALF0, 4 — carrier half-period in clk cycles for a space (bit 0); ≥1.
- HALF1, 2 — carrier half-period in clk cycles for a mark (bit 1); ≥1.
- PARITY_EN, 1 — 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
- word  in  8  data word; sampled on acceptance.
- word_valid  in  1  word is valid (upstream `enable`); level-sensitive.
- ready  out  1  block can accept a word this cycle.
- line_bit  out  1  current serialized bit; idle/mark = 1.
- busy  out  1  frame in progress (any state but IDLE).
- frame_done  out  1  one-cycle pulse in the last cycle of STOP.
- fsk_out  out  1  FSK carrier square wave.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept on a posedge where word_valid && ready. word is latched into the shift register; parity = XOR of the 8 bits (even parity) is latched.
- ready = (state==IDLE) || (state==STOP && bit_cnt==BIT_CYCLES-1). Combinational from registered state.
- IDLE: line_bit=1. On accept → START.
- START: line_bit=0 for BIT_CYCLES cycles → DATA.
- DATA: line_bit = shreg[0]; after each BIT_CYCLES cycles shift right and increment data index; after 8 bits → PARITY if PARITY_EN, else STOP.
- PARITY: line_bit = latched parity for BIT_CYCLES cycles → STOP.
- STOP: line_bit=1 for BIT_CYCLES cycles. In the last cycle frame_done=1; on exit go to START if accepting (back-to-back, zero gap), else IDLE.
- word_valid without ready is ignored; word changes mid-frame have no effect.
- Carrier: half counter increments each cycle. When cnt ≥ H−1, where H = line_bit ? HALF1 : HALF0, toggle fsk_out and clear cnt. The ≥ compare makes a tone change mid-half-period toggle at once if already past the new limit. No phase reset at bit boundaries. Carrier runs in IDLE at the mark tone.
- Widths: bit_cnt $clog2(BIT_CYCLES); data index 3 bits; carrier counter $clog2(max(HALF0,HALF1)), min 1.

## Timing
- Reset (rst=0 at posedge): state=IDLE, bit_cnt=0, shreg=0, carrier cnt=0, fsk_out=0, line_bit=1, busy=0, frame_done=0, ready=1. A frame in flight is abandoned; no partial stop bit.
- Accept at edge t: START (line_bit=0) visible from cycle t+1.
- Data bit i (0..7) occupies cycles t+1+(i+1)·BIT_CYCLES … +BIT_CYCLES−1.
- Frame length is (10+PARITY_EN)·BIT_CYCLES cycles. With word_valid held high, frames repeat with no idle gap.
- frame_done is asserted in the same cycle as the back-to-back accept.
- Carrier period is 2·HALF1 (mark) or 2·HALF0 (space) cycles in steady state.

## Structure
- Package fsk_pkg holds the state enum fsk_tx_state_t and default constants for BIT_CYCLES, HALF0 and HALF1.
- Sub-module fsk_carrier_gen (clk, rst, tone_sel, fsk_out; params HALF0/HALF1) contains the divider.
- The top module contains the FSM, bit timer and shift register.

## Test plan
- Reset release, word_valid=0 → line_bit=1, ready=1, busy=0; fsk_out toggles every 2 cycles (HALF1).
- Send 8'hA5, BIT_CYCLES=16, PARITY_EN=1 → line sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each held 16 cycles; frame_done at cycle 176 after accept.
- word_valid held high with words 01,02,04 (upstream pattern) → three contiguous frames, no idle cycles between stop and next start.
- PARITY_EN=0, send 8'h07 → 10-bit frame of 160 cycles with no parity slot.
- Tone change with carrier cnt=3 (HALF0=4 → HALF1=2) → fsk_out toggles on the next edge, then every 2 cycles.
- rst=0 during DATA bit 4 → next cycle line_bit=1, busy=0, ready=1; a new word sent afterwards yields a complete correct frame.
